// File: rtl/regfile_pkg.sv
// Shared state type and default dimensions for the register file.
package regfile_pkg;

   typedef enum logic {CLEAR, READY} rf_state_e;

   localparam int unsigned XLEN_DEFAULT   = 32;
   localparam int unsigned N_REGS_DEFAULT = 32;
   localparam int unsigned ADDR_W_DEFAULT = 5;

endpackage

// File: rtl/register_file_if.sv
// Read/write port bundle between the core (master) and the register file (slave).
interface register_file_if
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic [ADDR_W-1:0] rd;
   logic [XLEN-1:0]   rd_value;
   logic              we;
   logic [XLEN-1:0]   rs1_value;
   logic [XLEN-1:0]   rs2_value;
   logic              ready;

   modport master (
      output rs1, rs2, rd, rd_value, we,
      input  rs1_value, rs2_value, ready
   );

   modport slave (
      input  rs1, rs2, rd, rd_value, we,
      output rs1_value, rs2_value, ready
   );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks indices 1..N_REGS-1 issuing zero writes, then holds READY.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned N_REGS = N_REGS_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_REGS - 1);

   rf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_idx_q <= ADDR_W'(1);
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_we    = 1'b0;
      unique case (state_q)
         CLEAR: begin
            clr_we    = 1'b1;
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == LastIdx) state_d = READY;
         end
         READY: ;
      endcase
   end

   assign ready   = (state_q == READY);
   assign clr_idx = clr_idx_q;

endmodule

// File: rtl/register_file.sv
// Parametrised RV32 integer register file: 2 async read ports, 1 sync write port, x0 = 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEFAULT,
   parameter int unsigned N_REGS = N_REGS_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   register_file_if.slave  bus
);

   logic              ready;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic              port_we;
   logic [XLEN-1:0]   rs1_value;
   logic [XLEN-1:0]   rs2_value;

   // No storage for index 0.
   logic [XLEN-1:0] mem_q [1:N_REGS-1];

   function automatic logic idx_live(input logic [ADDR_W-1:0] idx);
      return (idx != '0) && (32'(idx) < N_REGS);
   endfunction

   regfile_clear_fsm #(
      .N_REGS (N_REGS),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk     (clk),
      .rst     (rst),
      .ready   (ready),
      .clr_we  (clr_we),
      .clr_idx (clr_idx)
   );

   // ready is low throughout CLEAR, so the two write sources never collide.
   assign port_we = ready && bus.we && idx_live(bus.rd);

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_idx] <= '0;
      end else if (port_we) begin
         mem_q[bus.rd] <= bus.rd_value;
      end
   end

   always_comb begin
      rs1_value = '0;
      rs2_value = '0;
      if (ready && idx_live(bus.rs1)) rs1_value = mem_q[bus.rs1];
      if (ready && idx_live(bus.rs2)) rs2_value = mem_q[bus.rs2];
`ifdef REGFILE_BYPASS_EN
      if (port_we && (bus.rs1 == bus.rd)) rs1_value = bus.rd_value;
      if (port_we && (bus.rs2 == bus.rd)) rs2_value = bus.rd_value;
`endif
   end

   assign bus.rs1_value = rs1_value;
   assign bus.rs2_value = rs2_value;
   assign bus.ready     = ready;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: one 32-entry and one 16-entry register file driven in lockstep.
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic [4:0]  rd = '0;
   logic [31:0] rd_value = '0;
   logic        we = 1'b0;

   always #5 clk = ~clk;

   register_file_if #(.XLEN(32), .ADDR_W(5)) bus_a ();
   register_file_if #(.XLEN(32), .ADDR_W(5)) bus_b ();

   assign bus_a.rs1 = rs1;
   assign bus_a.rs2 = rs2;
   assign bus_a.rd = rd;
   assign bus_a.rd_value = rd_value;
   assign bus_a.we = we;
   assign bus_b.rs1 = rs1;
   assign bus_b.rs2 = rs2;
   assign bus_b.rd = rd;
   assign bus_b.rd_value = rd_value;
   assign bus_b.we = we;

   register_file #(.XLEN(32), .N_REGS(32), .ADDR_W(5)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   register_file #(.XLEN(32), .N_REGS(16), .ADDR_W(5)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      logic        ar;
      logic [31:0] a1;
      logic [31:0] a2;
      logic        br;
      logic [31:0] b1;
      logic [31:0] b2;
   } exp_t;

   exp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;

   // Reference state: register contents per instance and edges since reset release.
   logic [31:0] ma [32];
   logic [31:0] mb [32];
   int          edges = 0;

   function automatic logic [31:0] exp_rd(input int n, input bit rdy, input logic [4:0] idx,
                                          input logic [31:0] stored, input bit w,
                                          input logic [4:0] wrd, input logic [31:0] v);
      if (!rdy || idx == 0 || int'(idx) >= n) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (w && wrd == idx) return v;
`endif
      return stored;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cycle(input bit r, input logic [4:0] a1, input logic [4:0] a2,
                        input bit w, input logic [4:0] wrd, input logic [31:0] v);
      exp_t e;
      bit   rdy_a, rdy_b;
      @(negedge clk);
      rst = r;
      rs1 = a1;
      rs2 = a2;
      we = w;
      rd = wrd;
      rd_value = v;
      rdy_a = !r && edges >= 31;
      rdy_b = !r && edges >= 15;
      e.ar = rdy_a;
      e.br = rdy_b;
      e.a1 = exp_rd(32, rdy_a, a1, ma[a1], w, wrd, v);
      e.a2 = exp_rd(32, rdy_a, a2, ma[a2], w, wrd, v);
      e.b1 = exp_rd(16, rdy_b, a1, mb[a1], w, wrd, v);
      e.b2 = exp_rd(16, rdy_b, a2, mb[a2], w, wrd, v);
      exp_q.push_back(e);
      @(posedge clk);
      if (r) begin
         edges = 0;
         for (int i = 0; i < 32; i++) begin
            ma[i] = '0;
            mb[i] = '0;
         end
      end else begin
         if (rdy_a && w && wrd != 0) ma[wrd] = v;
         if (rdy_b && w && wrd != 0 && wrd < 16) mb[wrd] = v;
         if (edges < 1000) edges++;
      end
   endtask

   task automatic rnd_cycle(input bit w);
      cycle(1'b0, 5'($urandom), 5'($urandom), w, 5'($urandom), $urandom);
   endtask

   task automatic sweep();
      for (int i = 0; i < 16; i++) cycle(1'b0, 5'(2 * i), 5'(2 * i + 1), 1'b0, '0, '0);
   endtask

   task automatic clear_wait(input bit w);
      for (int i = 0; i < 31; i++) rnd_cycle(w);
   endtask

   // Monitor: read ports are combinational, so outputs are sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("a_ready", 32'(bus_a.ready), 32'(e.ar));
            chk("a_rs1", bus_a.rs1_value, e.a1);
            chk("a_rs2", bus_a.rs2_value, e.a2);
            chk("b_ready", 32'(bus_b.ready), 32'(e.br));
            chk("b_rs1", bus_b.rs1_value, e.b1);
            chk("b_rs2", bus_b.rs2_value, e.b2);
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      cycle(1'b1, 5'd1, 5'd2, 1'b0, '0, '0);
      cycle(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'h1);
      // Clear with writes attempted on every edge, including the one where ready rises.
      clear_wait(1'b1);
      sweep();

      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
      cycle(1'b0, 5'd5, 5'd5, 1'b0, '0, '0);
      cycle(1'b0, 5'd5, 5'd0, 1'b1, 5'd0, 32'h12345678);
      cycle(1'b0, 5'd0, 5'd0, 1'b0, '0, '0);

      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1);
      cycle(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5);
      cycle(1'b0, 5'd7, 5'd0, 1'b0, '0, '0);

      cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h20202020);
      cycle(1'b0, 5'd20, 5'd15, 1'b0, '0, '0);

      for (int i = 0; i < 300; i++) rnd_cycle(($urandom % 2) == 0);

      // Fill everything, then reset mid-operation.
      for (int i = 1; i < 32; i++) cycle(1'b0, '0, '0, 1'b1, 5'(i), $urandom | 32'h1);
      cycle(1'b0, 5'd9, 5'd3, 1'b0, '0, '0);
      cycle(1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 32'hFFFF0000);
      clear_wait(1'b0);
      sweep();

      // Reset again part-way through the clear, with writes held on.
      cycle(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'h55);
      for (int i = 0; i < 11; i++) rnd_cycle(1'b1);
      cycle(1'b1, 5'd12, 5'd13, 1'b1, 5'd12, 32'h77);
      clear_wait(1'b1);
      cycle(1'b0, 5'd1, 5'd2, 1'b0, '0, '0);
      for (int i = 0; i < 50; i++) rnd_cycle(($urandom % 2) == 0);
      sweep();

      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
